mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the execute stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Operands come from the same rs/rt operand buses that feed the ALU. While an operation is in flight it raises busy so the controller stalls any following MFHI/MFLO or MDU instruction.

Parameters:
DATA_W, 32, operand and HI/LO width; only 32 is required to work.
ITERS, 32, iteration cycles per multiply/divide; must equal DATA_W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
a  input  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
b  input  32  rt operand (multiplier / divisor)
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  multiply/divide in progress
done  output  1  one-cycle pulse in the cycle HI/LO take a new mul/div result

Behaviour:
- Reset: asynchronous, active-high.
  - While rst=1: hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
  - Asserting rst mid-operation aborts the operation; no partial result is ever written.
- FSM states and transitions:
  - IDLE → RUN on start with op ∈ {000..011}.
  - RUN → FINISH when the iteration counter reaches ITERS-1.
  - FINISH → IDLE unconditionally.
- Sequencing of a mul/div (start sampled at edge E0):
  - Edge E0: operands, signs and the divide-by-zero flag are latched; busy=1 from E0.
  - Edges E1..E32: one iteration per edge.
  - Edge E33 (FINISH): hi/lo written; busy=0 and done=1 for exactly that one cycle.
  - Fixed latency: 33 edges from start to result, independent of operand values.
- MTHI/MTLO in IDLE: hi←a (or lo←a) at the sampling edge. No busy, no done, other register unchanged.
- Ignored requests:
  - start while busy=1, or during the FINISH cycle, is ignored; the controller must hold the request.
  - Reserved op codes are ignored: no state change.
- Multiply:
  - Unsigned: 32-step shift-add over a 64-bit accumulator.
  - Signed: multiply magnitudes; negate the 64-bit product if sign(a)≠sign(b).
  - Result: {hi,lo} = 64-bit product.
- Divide:
  - 32-step restoring division on magnitudes.
  - Signed quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Result: lo = quotient, hi = remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0, no trap.
- Divide by zero (b=0, DIV or DIVU):
  - Still takes the full 33 cycles.
  - Result is forced: lo=0xFFFFFFFF, hi=a (raw operand).
- hi/lo stay stable throughout RUN; previous values remain readable until FINISH.

Decomposition:
- Package mdu_pkg holds:
  - op code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - FSM state encoding (IDLE, RUN, FINISH);
  - ITERS.
- One sub-module, mdu_iter: the iterative datapath (64-bit accumulator/remainder register, shift-add / trial-subtract step, counter).
- mdu_hilo holds the FSM, sign/magnitude pre- and post-processing, the divide-by-zero override and the HI/LO registers.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done exactly 33 cycles after start; hi=0xFFFFFFFE lo=0x00000001; busy high for cycles 1-32 only.
2. MULT a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB.
3. DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3 hi=1.
4. DIVU a=0x12345678 b=0 → lo=0xFFFFFFFF hi=0x12345678 after 33 cycles. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000 hi=0.
5. MTHI a=0xDEADBEEF → hi=0xDEADBEEF next edge, busy/done stay 0. Then start MULTU 2×3, and pulse start with MTLO 0x55 at cycle 5 → MTLO ignored; final hi=0 lo=6.
6. Start DIVU 100/7, assert rst asynchronously mid-cycle at iteration 10 → hi=lo=0, busy=0, done=0 before the next clock edge. Release rst, start MULTU 4×5 → lo=20 hi=0 after 33 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op codes, FSM encoding and
// the default iteration count.
package mdu_pkg;
  localparam int ITERS = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring
// trial-subtract (divide) step per step cycle over a 2*DATA_W accumulator.
module mdu_iter #(
  parameter int DATA_W = 32,
  parameter int ITERS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_W-1:0]     opnd_in,
  input  logic [DATA_W-1:0]     init_in,
  output logic [2*DATA_W-1:0]   acc,
  output logic                  last
);
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W:0]   div_sh;
  logic [DATA_W:0]     div_diff;

  assign last = (cnt_q == LAST_CNT);
  assign acc  = acc_q;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[2*DATA_W:DATA_W] - {1'b0, opnd_q};
    if (load) begin
      acc_d  = {{DATA_W{1'b0}}, init_in};
      opnd_d = opnd_in;
      cnt_d  = '0;
    end else if (step) begin
      if (is_div) begin
        // A borrow means the trial subtract failed: keep the shifted remainder.
        if (div_diff[DATA_W]) acc_d = div_sh[2*DATA_W-1:0];
        else acc_d = {div_diff[DATA_W-1:0], div_sh[DATA_W-1:1], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
      end
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Sign handling and the divide-by-zero result are applied around mdu_iter.
module mdu_hilo #(
  parameter int DATA_W = 32,
  parameter int ITERS  = mdu_pkg::ITERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);
  import mdu_pkg::*;

  logic [1:0]          state_q, state_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   a_raw_q, a_raw_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                load;
  logic                last;
  logic                signed_op;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   acc_lo, acc_hi, quo, rem;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[DATA_W-1];
  assign b_neg     = signed_op & b[DATA_W-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign acc_lo = acc[DATA_W-1:0];
  assign acc_hi = acc[2*DATA_W-1:DATA_W];
  assign prod   = neg_q ? -acc : acc;
  assign quo    = neg_q ? -acc_lo : acc_lo;
  assign rem    = rem_neg_q ? -acc_hi : acc_hi;

  assign busy = (state_q == RUN);
  assign done = (state_q == FINISH);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = RUN;
              load      = 1'b1;
              is_div_d  = op[1];
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              dz_d      = (b == '0);
              a_raw_d   = a;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: if (last) state_d = FINISH;
      FINISH: begin
        state_d = IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (dz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Divisor/multiplicand go to opnd_in, dividend/multiplier seed the accumulator.
  mdu_iter #(.DATA_W(DATA_W), .ITERS(ITERS)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (busy),
    .is_div  (is_div_q),
    .opnd_in (op[1] ? b_mag : a_mag),
    .init_in (op[1] ? a_mag : b_mag),
    .acc     (acc),
    .last    (last)
  );
endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed cases plus randomized ops (with ignored
// requests injected mid-operation) checked against an arithmetic model.
module tb_mdu_hilo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_hilo #(.DATA_W(32), .ITERS(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] up;
    longint sx, sy, q, r, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'b000: begin p = sx * sy; return p; end
      3'b001: begin up = {32'b0, x} * {32'b0, y}; return up; end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 3'b011) return {x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one mul/div; optionally drives an ignored request at cycle intr_cyc.
  task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int intr_cyc, input logic [2:0] intr_op, input logic [31:0] intr_a);
    int cyc;
    int bad_busy;
    logic [63:0] e;
    exp_q.push_back(ref_md(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cyc = 1;
    bad_busy = 0;
    while (cyc < 40) begin
      if (cyc == intr_cyc) begin
        start = 1'b1; op = intr_op; a = intr_a;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (busy !== 1'b1) bad_busy++;
      if (hi !== m_hi || lo !== m_lo) bad_busy++;
      tick();
      cyc++;
    end
    check("latency", 64'(cyc), 64'd33);
    check("busy_run", 64'(bad_busy), 64'd0);
    check("busy_fin", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    check("done_pulse", 64'(done), 64'd0);
    e = exp_q.pop_front();
    check("hi", 64'(hi), 64'(e[63:32]));
    check("lo", 64'(lo), 64'(e[31:0]));
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
    op = o; a = x; start = 1'b1;
    tick();
    start = 1'b0;
    if (o == 3'b100) m_hi = x;
    if (o == 3'b101) m_lo = x;
    check("mt_busy", 64'(busy), 64'd0);
    check("mt_done", 64'(done), 64'd0);
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    int k;
    logic [31:0] x, y;
    tick();
    tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();

    run_md(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'b000, 32'h0);
    run_md(3'b000, 32'hFFFF_FFFD, 32'd7, 0, 3'b000, 32'h0);
    run_md(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 3'b000, 32'h0);
    run_md(3'b011, 32'd7, 32'd2, 0, 3'b000, 32'h0);
    run_md(3'b011, 32'h1234_5678, 32'd0, 0, 3'b000, 32'h0);
    run_md(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'b000, 32'h0);
    run_mt(3'b100, 32'hDEAD_BEEF);
    run_md(3'b001, 32'd2, 32'd3, 5, 3'b101, 32'h55);
    run_md(3'b000, 32'd9, 32'hFFFF_FFF0, 33, 3'b100, 32'hCAFE_F00D);
    run_mt(3'b110, 32'h1111_2222);
    run_mt(3'b101, 32'hA5A5_0001);

    // Async reset partway through a divide.
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    tick();
    run_md(3'b001, 32'd4, 32'd5, 0, 3'b000, 32'h0);

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 7);
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = $urandom_range(1, 15);
        default: y = $urandom;
      endcase
      if (k < 4) run_md(3'(k), x, y, $urandom_range(1, 38), 3'($urandom_range(0, 7)), $urandom);
      else run_mt(3'(k), x);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
